number_hit_detector: RTL and testbench
======================================

# number_hit_detector

Collision responder feeding the per-number hit inputs of the multi-number display. It counts, per frame, the pixels where the player's drawing request overlaps each number's drawing request. At each frame boundary it issues a one-cycle hit pulse for every number whose overlap reached a threshold and that has not been hit before. It sits between the VGA object muxing stage and the number display / game-control logic.

## Interface
- NUMBERS, 3: number of number objects; width of the DR input and hit output vectors.
- MIN_OVERLAP, 4: overlap pixels per frame required to qualify a hit; legal range 1..255.
- CNT_W, 8: width of each per-number overlap counter; must hold MIN_OVERLAP.
- HITS_W, 8: width of the total-hit counter.

Ports:
- clk  in  1  system clock; the pixel clock domain.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- enable  in  1  detection enable; 0 freezes counting and suppresses new hits.
- playerDR  in  1  player object drawing request for the current pixel.
- numbersDR  in  NUMBERS  per-number drawing requests for the current pixel.
- singleHit  out  NUMBERS  one-cycle hit pulse per number.
- anyHit  out  1  OR of singleHit, registered together with it.
- hitIndex  out  $clog2(NUMBERS) (min 1)  index of the lowest set bit of singleHit; held between pulses.
- hitMask  out  NUMBERS  sticky mask of numbers already hit.
- frameOverrun  out  1  sticky flag: startOfFrame arrived outside ACCUM.
- hitCount  out  HITS_W  total hits since reset (see Configuration).

## Operation
- FSM states are ACCUM, EVAL and PULSE; the reset state is ACCUM.
- **ACCUM:**
  - For each i, when enable=1, playerDR=1 and numbersDR[i]=1, cnt[i] increments. The counter saturates at 2^CNT_W-1.
  - On startOfFrame=1:
    - snap[i] <= cnt[i].
    - cnt[i] is reloaded with the overlap of the current pixel (0 or 1). That pixel belongs to the new frame.
    - The state moves to EVAL.
- **EVAL (1 cycle):**
  - qual[i] = (snap[i] >= MIN_OVERLAP) & ~hitMask[i] & enable.
  - singleHit <= qual; anyHit <= |qual; hitMask <= hitMask | qual.
  - If qual != 0, hitIndex <= lowest set index and hitCount advances by popcount(qual). The hitCount add saturates.
  - The state moves to PULSE.
- **PULSE (1 cycle):**
  - singleHit and anyHit are cleared.
  - The state moves to ACCUM.
- Counting continues in EVAL and PULSE into the fresh counters, so no pixel is lost.
- A startOfFrame seen in EVAL or PULSE is ignored for evaluation and sets frameOverrun. The counters are not cleared.
- Multiple numbers may be hit in the same frame: all are pulsed together, and hitIndex reports the lowest.
- A number is hit at most once between resets. hitMask is cleared only by reset.
- enable=0:
  - Counters hold their value.
  - Qualification is forced to 0.
  - The FSM still cycles on startOfFrame.

## Timing
- Reset values:
  - State is ACCUM.
  - cnt, snap, singleHit, anyHit, hitIndex, hitMask and hitCount are all 0.
  - frameOverrun is 0.
- Latency:
  - Call the cycle where startOfFrame is sampled cycle T.
  - singleHit and anyHit are high during cycle T+2 only.
  - hitMask, hitIndex and hitCount update at the same edge.
- singleHit is exactly one cycle wide, which makes it directly usable by the display's show-flag registers.
- Minimum spacing between startOfFrame pulses is 3 cycles. Closer pulses set frameOverrun.
- Reset asserted mid-EVAL or mid-PULSE:
  - Outputs drop to reset values immediately, asynchronously.
  - Any pending pulse is lost.

## Configuration
- HIT_COUNTER_EN:
  - Defined: the hitCount register and its saturating popcount adder are built.
  - Undefined: no counter logic is built and hitCount is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 10 frames with no overlap -> singleHit=0 throughout, hitMask=0, frameOverrun=0.
- MIN_OVERLAP=4; 4 overlap pixels with number 1 in frame 0, startOfFrame at cycle T:
  - singleHit=3'b010 during T+2 only.
  - hitIndex=1, hitMask=3'b010, hitCount=1.
- Same number overlapped again with 20 pixels in the next frame -> no pulse; hitCount stays 1.
- 3 overlap pixels only -> no hit. The pixel coincident with startOfFrame overlaps -> counted into the new frame, not the old one.
- Numbers 0 and 2 both qualify in one frame:
  - singleHit=3'b101 and hitIndex=0.
  - hitCount=2 with HIT_COUNTER_EN defined; hitCount=0 when it is undefined.
- Error and reset cases:
  - startOfFrame at T and T+1 -> frameOverrun=1 and a single pulse at T+2.
  - reset asserted at T+1 -> no pulse; all outputs return to 0.

Source files
------------

// File: rtl/number_hit_detector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// number_hit_detector
//
// Collision responder for the multi-number display. For every frame it counts
// the pixels where the player's drawing request overlaps each number's drawing
// request. At the frame boundary it raises a one-cycle hit pulse for every
// number whose overlap reached MIN_OVERLAP and that was never hit before.
//
// Optional feature macro: HIT_COUNTER_EN
//   defined   -> hitCount is a saturating total of hits since reset
//   undefined -> no counter logic, hitCount is tied to 0
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   startOfFrame one-cycle pulse at the first pixel of each frame
//   enable       detection enable (0 freezes counters, suppresses hits)
//   playerDR     player drawing request for the current pixel
//   numbersDR    per-number drawing requests for the current pixel
//   singleHit    one-cycle hit pulse per number
//   anyHit       OR of singleHit, registered alongside it
//   hitIndex     lowest index set in the last non-empty singleHit (held)
//   hitMask      sticky mask of numbers already hit
//   frameOverrun sticky: startOfFrame arrived while evaluating a frame
//   hitCount     total hits since reset (see HIT_COUNTER_EN)
// -----------------------------------------------------------------------------
module number_hit_detector #(
    parameter int NUMBERS     = 3,
    parameter int MIN_OVERLAP = 4,
    parameter int CNT_W       = 8,
    parameter int HITS_W      = 8,
    localparam int IDX_W      = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               playerDR,
    input  logic [NUMBERS-1:0] numbersDR,
    output logic [NUMBERS-1:0] singleHit,
    output logic               anyHit,
    output logic [IDX_W-1:0]   hitIndex,
    output logic [NUMBERS-1:0] hitMask,
    output logic               frameOverrun,
    output logic [HITS_W-1:0]  hitCount
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        EVAL  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [NUMBERS-1:0][CNT_W-1:0] cnt_reg;
    logic [NUMBERS-1:0][CNT_W-1:0] cnt_next;
    logic [NUMBERS-1:0][CNT_W-1:0] snap_reg;
    logic [NUMBERS-1:0]            overlap;
    logic [NUMBERS-1:0]            qual;
    logic [IDX_W-1:0]              low_idx;
    logic                          frame_accept;

    // Only a frame boundary seen in ACCUM closes the frame; one seen while
    // still evaluating the previous frame is flagged as an overrun instead.
    assign frame_accept = (state_reg == ACCUM) && startOfFrame;

    generate
        for (genvar gi = 0; gi < NUMBERS; gi++) begin : g_num
            assign overlap[gi] = enable & playerDR & numbersDR[gi];

            // On an accepted boundary the current pixel already belongs to the
            // new frame, so the counter restarts at 0 or 1 rather than 0.
            assign cnt_next[gi] =
                frame_accept ? CNT_W'(overlap[gi]) :
                (overlap[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) ? cnt_reg[gi] + 1'b1 :
                cnt_reg[gi];

            assign qual[gi] = (snap_reg[gi] >= CNT_W'(MIN_OVERLAP)) & ~hitMask[gi] & enable;
        end
    endgenerate

    // Lowest qualifying index: scan downwards so the lowest match wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (startOfFrame) state_next = EVAL;
            EVAL:    state_next = PULSE;
            PULSE:   state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ACCUM;
            cnt_reg      <= '0;
            snap_reg     <= '0;
            singleHit    <= '0;
            anyHit       <= 1'b0;
            hitIndex     <= '0;
            hitMask      <= '0;
            frameOverrun <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (frame_accept) begin
                snap_reg <= cnt_reg;
            end

            if (startOfFrame && (state_reg != ACCUM)) begin
                frameOverrun <= 1'b1;
            end

            case (state_reg)
                EVAL: begin
                    singleHit <= qual;
                    anyHit    <= |qual;
                    hitMask   <= hitMask | qual;
                    if (|qual) begin
                        hitIndex <= low_idx;
                    end
                end
                PULSE: begin
                    singleHit <= '0;
                    anyHit    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_COUNTER_EN
    localparam int PC_W = $clog2(NUMBERS + 1);

    logic [PC_W-1:0]   qual_cnt;
    logic [HITS_W:0]   hit_sum;

    always_comb begin
        qual_cnt = '0;
        for (int i = 0; i < NUMBERS; i++) begin
            qual_cnt = qual_cnt + PC_W'(qual[i]);
        end
    end

    // One spare bit catches the carry so the total sticks at all-ones.
    assign hit_sum = {1'b0, hitCount} + (HITS_W + 1)'(qual_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCount <= '0;
        end else if (state_reg == EVAL && (|qual)) begin
            hitCount <= hit_sum[HITS_W] ? {HITS_W{1'b1}} : hit_sum[HITS_W-1:0];
        end
    end
`else
    assign hitCount = '0;
`endif

endmodule

// File: tb/tb_number_hit_detector.sv
`timescale 1ns/1ps
module tb_number_hit_detector;

    localparam int NUM = 3;
    localparam int MIN = 4;
    localparam int CW  = 8;
    localparam int HW  = 8;
    localparam int IW  = 2;
`ifdef HIT_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic           startOfFrame;
    logic           enable;
    logic           playerDR;
    logic [NUM-1:0] numbersDR;
    logic [NUM-1:0] singleHit;
    logic           anyHit;
    logic [IW-1:0]  hitIndex;
    logic [NUM-1:0] hitMask;
    logic           frameOverrun;
    logic [HW-1:0]  hitCount;

    number_hit_detector #(
        .NUMBERS(NUM), .MIN_OVERLAP(MIN), .CNT_W(CW), .HITS_W(HW)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
        .playerDR(playerDR), .numbersDR(numbersDR), .singleHit(singleHit),
        .anyHit(anyHit), .hitIndex(hitIndex), .hitMask(hitMask),
        .frameOverrun(frameOverrun), .hitCount(hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outcome of one frame evaluation, due in a given cycle slot.
    typedef struct {
        int             due;
        logic [NUM-1:0] sh;
        logic           any;
        logic [IW-1:0]  idx;
        logic [NUM-1:0] mask;
        logic [HW-1:0]  cnt;
        logic           ovr;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: per-frame overlap tallies and hit bookkeeping.
    int             m_cnt [NUM];
    int             m_snap[NUM];
    logic [NUM-1:0] m_mask;
    int             m_hits;
    int             m_idx;
    bit             m_ovr;
    bit             m_pending;
    int             m_last_sof;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [HW-1:0] exp_count();
        if (!CNT_EN) return '0;
        return (m_hits > 255) ? 8'hFF : HW'(m_hits);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_mask     = '0;
        m_hits     = 0;
        m_idx      = 0;
        m_ovr      = 1'b0;
        m_pending  = 1'b0;
        m_last_sof = -100;
    endfunction

    // One cycle slot: drive inputs and advance the reference model.
    task automatic drive(bit sof, bit en, bit p, logic [NUM-1:0] n);
        bit             eval_now;
        logic [NUM-1:0] q;
        exp_t           rec;
        @(posedge clk);
        #1;
        cyc++;
        startOfFrame = sof;
        enable       = en;
        playerDR     = p;
        numbersDR    = n;

        eval_now  = m_pending;
        m_pending = 1'b0;

        // A frame boundary is honoured only 3+ cycles after the previous one.
        if (sof && (cyc - m_last_sof >= 3)) begin
            for (int i = 0; i < NUM; i++) begin
                m_snap[i] = m_cnt[i];
                m_cnt[i]  = (en && p && n[i]) ? 1 : 0;
            end
            m_pending  = 1'b1;
            m_last_sof = cyc;
        end else begin
            if (sof) m_ovr = 1'b1;
            for (int i = 0; i < NUM; i++) begin
                if (en && p && n[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
        end

        if (eval_now) begin
            for (int i = 0; i < NUM; i++) begin
                q[i] = (m_snap[i] >= MIN) && !m_mask[i] && en;
            end
            if (q != '0) begin
                for (int i = NUM - 1; i >= 0; i--) if (q[i]) m_idx = i;
                m_hits += $countones(q);
            end
            m_mask  = m_mask | q;
            rec.due  = cyc + 1;
            rec.sh   = q;
            rec.any  = |q;
            rec.idx  = IW'(m_idx);
            rec.mask = m_mask;
            rec.cnt  = exp_count();
            rec.ovr  = m_ovr;
            sbq.push_back(rec);
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(int n, string tag);
        @(posedge clk);
        #1;
        cyc++;
        reset        = 1'b1;
        startOfFrame = 1'b0;
        enable       = 1'b0;
        playerDR     = 1'b0;
        numbersDR    = '0;
        model_reset();
        sbq.delete();
        #1;
        check({tag, "_singleHit"}, 32'(singleHit), 0);
        check({tag, "_anyHit"}, 32'(anyHit), 0);
        check({tag, "_hitIndex"}, 32'(hitIndex), 0);
        check({tag, "_hitMask"}, 32'(hitMask), 0);
        check({tag, "_frameOverrun"}, 32'(frameOverrun), 0);
        check({tag, "_hitCount"}, 32'(hitCount), 0);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    task automatic check_state(string tag);
        idle(4);
        check({tag, "_hitMask"}, 32'(hitMask), 32'(m_mask));
        check({tag, "_frameOverrun"}, 32'(frameOverrun), 32'(m_ovr));
        check({tag, "_hitCount"}, 32'(hitCount), 32'(exp_count()));
        $display("state %s: hitMask=%b frameOverrun=%0d hitCount=%0d", tag, hitMask, frameOverrun, hitCount);
    endtask

    // Monitor: pops an expected record when its slot arrives; otherwise the
    // pulse outputs must be quiet.
    always @(negedge clk) begin
        if (!reset) begin
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                check("eval_slot", 32'(cyc), 32'(sbq[0].due));
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                $display("eval cycle %0d: singleHit=%b anyHit=%0d hitIndex=%0d hitMask=%b hitCount=%0d overrun=%0d (exp %b %0d %0d %b %0d %0d)",
                         cyc, singleHit, anyHit, hitIndex, hitMask, hitCount, frameOverrun,
                         e.sh, e.any, e.idx, e.mask, e.cnt, e.ovr);
                check("singleHit", 32'(singleHit), 32'(e.sh));
                check("anyHit", 32'(anyHit), 32'(e.any));
                check("hitIndex", 32'(hitIndex), 32'(e.idx));
                check("hitMask", 32'(hitMask), 32'(e.mask));
                check("hitCount", 32'(hitCount), 32'(e.cnt));
                check("frameOverrun", 32'(frameOverrun), 32'(e.ovr));
            end else begin
                check("idle_pulse", 32'({anyHit, singleHit}), 0);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        enable       = 1'b0;
        playerDR     = 1'b0;
        numbersDR    = '0;
        model_reset();

        // Ten frames with numbers drawn but no player overlap.
        do_reset(2, "rst0");
        repeat (10) begin
            repeat (7) drive(1'b0, 1'b1, 1'b0, 3'($urandom));
            drive(1'b1, 1'b1, 1'b0, 3'b111);
        end
        check_state("no_overlap");

        // Exactly MIN_OVERLAP pixels on number 1.
        repeat (4) drive(1'b0, 1'b1, 1'b1, 3'b010);
        idle(3);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_state("hit_n1");

        // Number 1 already hit: heavy overlap must not pulse again.
        repeat (20) drive(1'b0, 1'b1, 1'b1, 3'b010);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_state("rehit_n1");

        // 3 pixels then an overlapping boundary pixel: no hit, pixel moves
        // to the next frame, which then reaches 4 with 3 more.
        repeat (3) drive(1'b0, 1'b1, 1'b1, 3'b001);
        drive(1'b1, 1'b1, 1'b1, 3'b001);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 3'b001);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_state("boundary_pixel");

        // Numbers 0 and 2 together.
        do_reset(1, "rst1");
        repeat (5) drive(1'b0, 1'b1, 1'b1, 3'b101);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_state("dual_hit");

        // Back-to-back frame boundaries.
        do_reset(1, "rst2");
        repeat (4) drive(1'b0, 1'b1, 1'b1, 3'b100);
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, '0);
        check_state("overrun");

        // Reset during evaluation kills the pending pulse.
        do_reset(1, "rst3");
        repeat (4) drive(1'b0, 1'b1, 1'b1, 3'b011);
        drive(1'b1, 1'b1, 1'b0, '0);
        do_reset(2, "rst_mid_eval");
        check_state("after_mid_reset");

        // Randomized frames, with periodic resets to re-arm the numbers.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset(1, "rst_rand");
            for (int f = 0; f < 8; f++) begin
                int len;
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12);
                for (int k = 0; k < len - 1; k++) begin
                    drive(1'b0, $urandom_range(0, 5) != 0, 1'($urandom), 3'($urandom));
                end
                drive(1'b1, 1'b1, 1'($urandom), 3'($urandom));
            end
            check_state("rand_epoch");
        end

        idle(6);
        check("scoreboard_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
